// File: rtl/contador_programa_pkg.sv
// Purpose : shared definitions for the fetch program counter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: 2-bit FSM state encoding and the default reset fetch vector.
package contador_programa_pkg;

  // Fetch sequencer state; 2'b11 is unused and treated as a dead state.
  typedef enum logic [1:0] {
    ARRANQUE = 2'b00,  // single warm-up cycle after reset release
    BUSCAR   = 2'b01,  // issuing sequential fetches
    ERROR    = 2'b10   // misaligned redirect seen; frozen until reset
  } estado_t;

  // Default first fetch address after reset (word aligned).
  localparam logic [31:0] VECTOR_RESET_DEF = 32'h0000_0000;

endpackage : contador_programa_pkg

// File: rtl/contador_programa.sv
// Purpose : program counter / fetch request sequencer for the front end.
// Latency : new address visible one clock after the accept or redirect edge.
// Backpressure: holds pc_out while fetch_listo=0 or detener=1; redirect overrides both.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   pc_out              current fetch address (operand A of external PC+4 adder)
//   pc_mas4             adder return, pc_out + 4
//   salto_valido/destino redirect request and target from execute
//   detener             hazard-unit stall
//   fetch_valido/listo  valid-ready fetch handshake with instruction memory
//   error_alineacion    sticky misaligned-redirect flag
//   contador_busquedas  count of accepted fetches (wraps mod 2^32)
module contador_programa
  import contador_programa_pkg::*;
#(
  parameter logic [31:0] VECTOR_RESET = VECTOR_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_mas4,
  input  logic        salto_valido,
  input  logic [31:0] salto_destino,
  input  logic        detener,
  output logic        fetch_valido,
  input  logic        fetch_listo,
  output logic        error_alineacion,
  output logic [31:0] contador_busquedas
);

  estado_t     estado_q;
  estado_t     estado_d;
  // Only the word index is stored, so the low address bits read 00 by construction.
  logic [31:2] pc_q;
  logic [31:0] cnt_q;
  logic        err_q;
  logic        salto_desalineado;
  logic        acepta;
  logic        unused_bits;

  assign salto_desalineado = salto_valido && (salto_destino[1:0] != 2'b00);
  assign acepta            = fetch_valido && fetch_listo;

  // Low bits of the adder return are always 00 for an aligned PC; not needed.
  assign unused_bits = ^pc_mas4[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ARRANQUE;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ARRANQUE: estado_d = BUSCAR;
      BUSCAR:   if (salto_desalineado) estado_d = ERROR;
      ERROR:    estado_d = ERROR;
      default:  estado_d = ERROR;
    endcase
  end

  // Output logic: a stall withdraws the request combinationally.
  always_comb begin
    fetch_valido = 1'b0;
    if (estado_q == BUSCAR) begin
      fetch_valido = !detener;
    end
  end

  // Datapath: redirect has priority over accept and over stall. A misaligned
  // target leaves the PC untouched and only raises the sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= VECTOR_RESET[31:2];
      cnt_q <= 32'd0;
      err_q <= 1'b0;
    end else if (estado_q == BUSCAR) begin
      if (salto_valido) begin
        if (salto_desalineado) begin
          err_q <= 1'b1;
        end else begin
          pc_q <= salto_destino[31:2];
        end
      end else if (acepta) begin
        pc_q  <= pc_mas4[31:2];
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign pc_out             = {pc_q, 2'b00};
  assign contador_busquedas = cnt_q;
  assign error_alineacion   = err_q;

endmodule : contador_programa

// File: tb/tb_contador_programa.sv
module tb_contador_programa;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] pc_mas4;
  logic        salto_valido;
  logic [31:0] salto_destino;
  logic        detener;
  logic        fetch_valido;
  logic        fetch_listo;
  logic        error_alineacion;
  logic [31:0] contador_busquedas;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        fv;
    logic        err;
  } exp_t;

  exp_t sb[$];

  contador_programa dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pc_out             (pc_out),
    .pc_mas4            (pc_mas4),
    .salto_valido       (salto_valido),
    .salto_destino      (salto_destino),
    .detener            (detener),
    .fetch_valido       (fetch_valido),
    .fetch_listo        (fetch_listo),
    .error_alineacion   (error_alineacion),
    .contador_busquedas (contador_busquedas)
  );

  // External PC+4 adder, as it sits outside the block in the real pipeline.
  assign pc_mas4 = pc_out + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic listo, input logic det,
                       input logic sv, input logic [31:0] dest);
    fetch_listo   = listo;
    detener       = det;
    salto_valido  = sv;
    salto_destino = dest;
  endtask

  task automatic expect_st(input string tag, input logic [31:0] pc,
                           input logic [31:0] cnt, input logic fv, input logic err);
    exp_t e;
    e.tag = tag; e.pc = pc; e.cnt = cnt; e.fv = fv; e.err = err;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (pc_out === e.pc) else begin
        bad++;
        $error("FAIL %s pc_out observed=%h expected=%h", e.tag, pc_out, e.pc);
      end
      total++;
      assert (contador_busquedas === e.cnt) else begin
        bad++;
        $error("FAIL %s contador observed=%0d expected=%0d", e.tag, contador_busquedas, e.cnt);
      end
      total++;
      assert (fetch_valido === e.fv) else begin
        bad++;
        $error("FAIL %s fetch_valido observed=%b expected=%b", e.tag, fetch_valido, e.fv);
      end
      total++;
      assert (error_alineacion === e.err) else begin
        bad++;
        $error("FAIL %s error_alineacion observed=%b expected=%b", e.tag, error_alineacion, e.err);
      end
    end
  endtask

  // Check without a clock edge (combinational / async-reset effects).
  task automatic now_chk();
    #1;
    chk();
  endtask

  // Check one time unit after the next rising edge.
  task automatic clk_chk();
    @(posedge clk);
    #1;
    chk();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_st("reset", 32'h0, 32'd0, 1'b0, 1'b0);
    now_chk();

    // Release reset mid-cycle; first cycle is ARRANQUE with no request.
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_st("arranque", 32'h0, 32'd0, 1'b0, 1'b0);
    now_chk();

    // A redirect during ARRANQUE must be ignored.
    drive(1'b1, 1'b0, 1'b1, 32'h500);
    expect_st("arranque_salto", 32'h0, 32'd0, 1'b1, 1'b0);
    clk_chk();

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_st("acc_4", 32'h4, 32'd1, 1'b1, 1'b0);
    clk_chk();
    expect_st("acc_8", 32'h8, 32'd2, 1'b1, 1'b0);
    clk_chk();

    // Memory not ready for three cycles: address and count held.
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      expect_st("wait_listo", 32'h8, 32'd2, 1'b1, 1'b0);
      clk_chk();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_st("acc_c", 32'hC, 32'd3, 1'b1, 1'b0);
    clk_chk();

    // Stall drops the request and ignores fetch_listo.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    expect_st("detener", 32'hC, 32'd3, 1'b0, 1'b0);
    clk_chk();

    // Redirect wins over stall.
    drive(1'b1, 1'b1, 1'b1, 32'h100);
    expect_st("detener_salto", 32'h100, 32'd3, 1'b0, 1'b0);
    clk_chk();

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_st("acc_104", 32'h104, 32'd4, 1'b1, 1'b0);
    clk_chk();

    // Redirect wins over an accepted fetch: no count.
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    expect_st("salto_200", 32'h200, 32'd4, 1'b1, 1'b0);
    clk_chk();

    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    expect_st("salto_top", 32'hFFFF_FFFC, 32'd4, 1'b1, 1'b0);
    clk_chk();

    // Address wrap to zero is legal.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_st("wrap", 32'h0, 32'd5, 1'b1, 1'b0);
    clk_chk();

    drive(1'b1, 1'b0, 1'b1, 32'h20);
    expect_st("salto_20", 32'h20, 32'd5, 1'b1, 1'b0);
    clk_chk();

    // Pending fetch at 0x20, reset asserted mid-cycle before the accept edge.
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #3;
    rst_n = 1'b0;
    expect_st("rst_mid", 32'h0, 32'd0, 1'b0, 1'b0);
    now_chk();
    expect_st("rst_hold", 32'h0, 32'd0, 1'b0, 1'b0);
    clk_chk();

    rst_n = 1'b1;
    expect_st("arranque2", 32'h0, 32'd0, 1'b0, 1'b0);
    now_chk();
    expect_st("buscar2", 32'h0, 32'd0, 1'b1, 1'b0);
    clk_chk();

    // Misaligned target: PC held, sticky error, request withdrawn.
    drive(1'b1, 1'b0, 1'b1, 32'h102);
    expect_st("desalineado", 32'h0, 32'd0, 1'b0, 1'b1);
    clk_chk();

    drive(1'b1, 1'b0, 1'b1, 32'h300);
    expect_st("error_salto", 32'h0, 32'd0, 1'b0, 1'b1);
    clk_chk();

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    expect_st("error_hold", 32'h0, 32'd0, 1'b0, 1'b1);
    clk_chk();

    // Only reset leaves ERROR.
    rst_n = 1'b0;
    expect_st("rst_error", 32'h0, 32'd0, 1'b0, 1'b0);
    now_chk();
    #2;
    rst_n = 1'b1;
    expect_st("buscar3", 32'h0, 32'd0, 1'b1, 1'b0);
    clk_chk();
    expect_st("acc_post", 32'h4, 32'd1, 1'b1, 1'b0);
    clk_chk();

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_contador_programa
